// File: rtl/producao_pkg.sv
// rtl/producao_pkg.sv - shared types and BCD helpers for the production counter
package producao_pkg;

    typedef enum logic [1:0] {IDLE, RUN, EMPTY, FULL} state_t;

    localparam int BCD_DIGIT_W = 4;

    function automatic logic [15:0] int_to_bcd(input int value, input int digits);
        logic [15:0] r;
        int          v;
        r = '0;
        v = value;
        for (int i = 0; i < 4; i++) begin
            if (i < digits) r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Valid BCD orders exactly like binary once the digits are aligned.
    function automatic logic bcd_le(input logic [15:0] a, input logic [15:0] b);
        return a <= b;
    endfunction

endpackage

// File: rtl/bcd_counter_n.sv
// rtl/bcd_counter_n.sv - N-digit saturating BCD up/down counter with load
module bcd_counter_n
    import producao_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          inc,
    input  logic                          dec,
    input  logic                          load,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] load_value,
    output logic [BCD_DIGIT_W*DIGITS-1:0] q
);

    localparam int W = BCD_DIGIT_W * DIGITS;
    localparam logic [W-1:0] ALL_NINE = {DIGITS{4'h9}};

    logic [W-1:0] q_up;
    logic [W-1:0] q_down;
    logic         carry;
    logic         borrow;

    always_comb begin
        q_up   = q;
        q_down = q;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
                    q_up[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
                end else begin
                    q_up[i*BCD_DIGIT_W +: BCD_DIGIT_W] = q[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0) begin
                    q_down[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd9;
                end else begin
                    q_down[i*BCD_DIGIT_W +: BCD_DIGIT_W] = q[i*BCD_DIGIT_W +: BCD_DIGIT_W] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_value;
        end else if (inc && !dec && q != ALL_NINE) begin
            q <= q_up;
        end else if (dec && !inc && q != '0) begin
            q <= q_down;
        end
    end

endmodule

// File: rtl/contador_producao_param.sv
// rtl/contador_producao_param.sv - bottle batch and cork stock counter for the bottling line
module contador_producao_param
    import producao_pkg::*;
#(
    parameter int BATCH_SIZE   = 12,
    parameter int BATCH_DIGITS = 2,
    parameter int MAX_BATCHES  = 10,
    parameter int FULL_MODE    = 0,
    parameter int STOCK_DIGITS = 2,
    parameter int STOCK_LOW    = 5,
    parameter int AUTO_REFILL  = 1,
    parameter int REFILL_VALUE = 99
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                seal,
    input  logic                                cork_add,
    input  logic                                clear,
    output logic [7:0]                          item_count,
    output logic [BCD_DIGIT_W*BATCH_DIGITS-1:0] batch_bcd,
    output logic [BCD_DIGIT_W*STOCK_DIGITS-1:0] stock_bcd,
    output logic                                batch_done,
    output logic                                lot_full,
    output logic                                stock_low,
    output logic                                stock_empty,
    output logic                                seal_error
);

    localparam int BW = BCD_DIGIT_W * BATCH_DIGITS;
    localparam int SW = BCD_DIGIT_W * STOCK_DIGITS;
    localparam logic [BW-1:0] MAX_BCD       = BW'(int_to_bcd(MAX_BATCHES, BATCH_DIGITS));
    localparam logic [BW-1:0] PRE_MAX_BCD   = BW'(int_to_bcd(MAX_BATCHES - 1, BATCH_DIGITS));
    localparam logic [SW-1:0] REFILL_BCD    = SW'(int_to_bcd(REFILL_VALUE, STOCK_DIGITS));
    localparam logic [15:0]   STOCK_LOW_BCD = int_to_bcd(STOCK_LOW, 4);
    localparam logic [7:0]    LAST_ITEM     = 8'(BATCH_SIZE - 1);
    localparam bit            FULL_HOLD     = (FULL_MODE != 0);
    localparam bit            REFILL_ON     = (AUTO_REFILL != 0);

    state_t state;

    logic active;
    logic stock_zero;
    logic stock_one;
    logic batch_at_max;
    logic batch_pre_max;
    logic full_block;
    logic cork_eff;
    logic seal_ok;
    logic seal_rej;
    logic batch_step;
    logic batch_wrap;
    logic stock_refill;
    logic stock_next_zero;

    assign active        = enable && (state != IDLE);
    assign stock_zero    = (stock_bcd == '0);
    assign stock_one     = (stock_bcd == SW'(1));
    assign batch_at_max  = (batch_bcd == MAX_BCD);
    assign batch_pre_max = (batch_bcd == PRE_MAX_BCD);

    // In hold mode a lot sitting at the limit blocks sealing even if the FSM
    // was bounced through IDLE by enable.
    assign full_block = FULL_HOLD && batch_at_max;

    assign cork_eff   = active && cork_add;
    assign seal_ok    = enable && (state == RUN) && seal && !clear && !stock_zero && !full_block;
    assign seal_rej   = enable && seal && !clear &&
                        ((state == EMPTY) || (state == FULL) ||
                         ((state == RUN) && (stock_zero || full_block)));
    assign batch_step = seal_ok && (item_count == LAST_ITEM);
    assign batch_wrap = batch_step && batch_pre_max && !FULL_HOLD;

    assign stock_refill    = REFILL_ON && stock_zero;
    assign stock_next_zero = !cork_eff && (stock_zero || (stock_one && seal_ok));

    bcd_counter_n #(
        .DIGITS(BATCH_DIGITS)
    ) u_batch (
        .clock      (clock),
        .reset      (reset),
        .inc        (batch_step),
        .dec        (1'b0),
        .load       (clear || batch_wrap),
        .load_value ('0),
        .q          (batch_bcd)
    );

    bcd_counter_n #(
        .DIGITS(STOCK_DIGITS)
    ) u_stock (
        .clock      (clock),
        .reset      (reset),
        .inc        (cork_eff),
        .dec        (seal_ok),
        .load       (stock_refill),
        .load_value (REFILL_BCD),
        .q          (stock_bcd)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            item_count <= 8'd0;
            batch_done <= 1'b0;
            seal_error <= 1'b0;
        end else begin
            batch_done <= batch_step;
            seal_error <= seal_rej;

            if (clear) begin
                item_count <= 8'd0;
            end else if (seal_ok) begin
                item_count <= (item_count == LAST_ITEM) ? 8'd0 : item_count + 8'd1;
            end

            if (!enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:  state <= RUN;
                    RUN: begin
                        if (FULL_HOLD && ((batch_step && batch_pre_max) || (batch_at_max && !clear))) begin
                            state <= FULL;
                        end else if (!REFILL_ON && stock_next_zero) begin
                            state <= EMPTY;
                        end
                    end
                    EMPTY: if (cork_add) state <= RUN;
                    FULL:  if (clear) state <= RUN;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign lot_full    = (state == FULL);
    assign stock_low   = bcd_le(16'(stock_bcd), STOCK_LOW_BCD);
    assign stock_empty = !REFILL_ON && stock_zero;

endmodule

// File: tb/tb_contador_producao_param.sv
// tb/tb_contador_producao_param.sv - randomized model-checked bench for contador_producao_param
module tb_contador_producao_param;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_EMPTY = 2;
    localparam int S_FULL  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic seal = 1'b0;
    logic cork_add = 1'b0;
    logic clear = 1'b0;

    logic [7:0] item_a, item_b;
    logic [7:0] batch_a, stock_a;
    logic [3:0] batch_b, stock_b;
    logic done_a, full_a, low_a, empty_a, err_a;
    logic done_b, full_b, low_b, empty_b, err_b;

    int n_checks = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    int p_bs[2]   = '{12, 3};
    int p_bd[2]   = '{2, 1};
    int p_max[2]  = '{10, 4};
    int p_fm[2]   = '{0, 1};
    int p_sd[2]   = '{2, 1};
    int p_smax[2] = '{99, 9};
    int p_low[2]  = '{5, 2};
    int p_ar[2]   = '{1, 0};
    int p_ref[2]  = '{99, 9};

    int m_st[2]    = '{0, 0};
    int m_stock[2] = '{0, 0};
    int m_batch[2] = '{0, 0};
    int m_item[2]  = '{0, 0};
    bit m_done[2]  = '{0, 0};
    bit m_err[2]   = '{0, 0};

    always #5 clk = ~clk;

    contador_producao_param u_a (
        .clock(clk), .reset(rst_n), .enable(enable), .seal(seal), .cork_add(cork_add), .clear(clear),
        .item_count(item_a), .batch_bcd(batch_a), .stock_bcd(stock_a), .batch_done(done_a),
        .lot_full(full_a), .stock_low(low_a), .stock_empty(empty_a), .seal_error(err_a)
    );

    contador_producao_param #(
        .BATCH_SIZE(3), .BATCH_DIGITS(1), .MAX_BATCHES(4), .FULL_MODE(1),
        .STOCK_DIGITS(1), .STOCK_LOW(2), .AUTO_REFILL(0), .REFILL_VALUE(9)
    ) u_b (
        .clock(clk), .reset(rst_n), .enable(enable), .seal(seal), .cork_add(cork_add), .clear(clear),
        .item_count(item_b), .batch_bcd(batch_b), .stock_bcd(stock_b), .batch_done(done_b),
        .lot_full(full_b), .stock_low(low_b), .stock_empty(empty_b), .seal_error(err_b)
    );

    function automatic int to_bcd(input int v, input int digits);
        int r = 0;
        int x = v;
        for (int i = 0; i < digits; i++) begin
            r += (x % 10) << (4 * i);
            x /= 10;
        end
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input int i);
        int  ns, nstock, nbatch, nitem;
        bit  ok, done, err, at_max;
        if (!rst_n) begin
            m_st[i] = S_IDLE; m_stock[i] = 0; m_batch[i] = 0; m_item[i] = 0;
            m_done[i] = 0; m_err[i] = 0;
            return;
        end
        ns = m_st[i]; nstock = m_stock[i]; nbatch = m_batch[i]; nitem = m_item[i];
        ok = 0; done = 0; err = 0;
        at_max = (p_fm[i] != 0) && (m_batch[i] == p_max[i]);
        if (clear) begin
            nbatch = 0;
            nitem = 0;
        end
        if (!enable) begin
            ns = S_IDLE;
        end else begin
            case (m_st[i])
                S_IDLE: ns = S_RUN;
                S_RUN: begin
                    ok  = seal && !clear && m_stock[i] > 0 && !at_max;
                    err = seal && !clear && !ok;
                    if (ok) begin
                        nitem = m_item[i] + 1;
                        if (nitem == p_bs[i]) begin
                            nitem = 0;
                            done = 1;
                            nbatch = m_batch[i] + 1;
                            if (nbatch == p_max[i]) begin
                                if (p_fm[i] == 0) nbatch = 0;
                                else ns = S_FULL;
                            end
                        end
                    end
                    if (at_max && !clear) ns = S_FULL;
                    nstock = m_stock[i] + int'(cork_add) - int'(ok);
                    if (nstock > p_smax[i]) nstock = p_smax[i];
                    if (ns == S_RUN && p_ar[i] == 0 && nstock == 0) ns = S_EMPTY;
                end
                S_EMPTY: begin
                    err = seal && !clear;
                    if (cork_add) begin
                        nstock = (m_stock[i] < p_smax[i]) ? m_stock[i] + 1 : p_smax[i];
                        ns = S_RUN;
                    end
                end
                default: begin
                    err = seal && !clear;
                    if (cork_add) nstock = (m_stock[i] < p_smax[i]) ? m_stock[i] + 1 : p_smax[i];
                    if (clear) ns = S_RUN;
                end
            endcase
        end
        if (p_ar[i] != 0 && m_stock[i] == 0) nstock = p_ref[i];
        m_st[i] = ns; m_stock[i] = nstock; m_batch[i] = nbatch; m_item[i] = nitem;
        m_done[i] = done; m_err[i] = err;
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("item_a",  item_a,  m_item[0]);
            cmp("batch_a", batch_a, to_bcd(m_batch[0], p_bd[0]));
            cmp("stock_a", stock_a, to_bcd(m_stock[0], p_sd[0]));
            cmp("done_a",  done_a,  m_done[0]);
            cmp("err_a",   err_a,   m_err[0]);
            cmp("full_a",  full_a,  m_st[0] == S_FULL);
            cmp("low_a",   low_a,   m_stock[0] <= p_low[0]);
            cmp("empty_a", empty_a, m_stock[0] == 0 && p_ar[0] == 0);
            cmp("item_b",  item_b,  m_item[1]);
            cmp("batch_b", batch_b, to_bcd(m_batch[1], p_bd[1]));
            cmp("stock_b", stock_b, to_bcd(m_stock[1], p_sd[1]));
            cmp("done_b",  done_b,  m_done[1]);
            cmp("err_b",   err_b,   m_err[1]);
            cmp("full_b",  full_b,  m_st[1] == S_FULL);
            cmp("low_b",   low_b,   m_stock[1] <= p_low[1]);
            cmp("empty_b", empty_b, m_stock[1] == 0 && p_ar[1] == 0);
        end
    end

    task automatic pulse(input bit s, input bit c, input bit k);
        seal = s; cork_add = c; clear = k;
        @(negedge clk);
        seal = 0; cork_add = 0; clear = 0;
    endtask

    int sp[4] = '{50, 20, 50, 70};
    int cp[4] = '{20, 60, 50, 10};

    initial begin
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        cmp("lit_rst_item_a", item_a, 0);
        cmp("lit_rst_batch_a", batch_a, 0);
        cmp("lit_rst_stock_a", stock_a, 0);
        cmp("lit_rst_done_a", done_a, 0);
        cmp("lit_rst_empty_b", empty_b, 1);

        rst_n = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        cmp("lit_refill_a", stock_a, 'h99);
        cmp("lit_no_empty_a", empty_a, 0);
        @(negedge clk);
        repeat (3) pulse(0, 1, 0);
        cmp("lit_sat_a", stock_a, 'h99);
        cmp("lit_cork_b", stock_b, 3);
        repeat (4) pulse(1, 0, 0);
        cmp("lit_err_b", err_b, 1);
        cmp("lit_item_b", item_b, 0);
        cmp("lit_batch_b", batch_b, 1);
        cmp("lit_empty_b", empty_b, 1);
        cmp("lit_stock_a", stock_a, 'h95);
        cmp("lit_item_a", item_a, 4);

        pulse(1, 0, 1);
        cmp("lit_clr_item_a", item_a, 0);
        cmp("lit_clr_err_a", err_a, 0);
        cmp("lit_clr_batch_b", batch_b, 0);
        cmp("lit_clr_err_b", err_b, 0);

        rst_n = 1'b0;
        @(negedge clk);
        cmp("lit_rst2_stock_a", stock_a, 0);
        cmp("lit_rst2_item_a", item_a, 0);
        rst_n = 1'b1;

        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 900; c++) begin
                seal     = ($urandom_range(99) < sp[seg]);
                cork_add = ($urandom_range(99) < cp[seg]);
                clear    = ($urandom_range(199) == 0);
                if (enable) enable = ($urandom_range(59) != 0);
                else        enable = ($urandom_range(2) == 0);
                rst_n    = ($urandom_range(1499) != 0);
                @(negedge clk);
            end
        end
        seal = 0; cork_add = 0; clear = 0; rst_n = 1'b1;
        @(negedge clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
